// File: rtl/codec_cfg_seq.sv
// codec_cfg_seq: boot-time sequencer that writes an external register table to the
// audio codec over I2C. Define CODEC_CFG_RETRY_EN to retry a NACKed entry up to 3 times.
module codec_cfg_seq #(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         NUM_REGS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic [7:0]  err_idx,
    output logic [7:0]  cfg_idx,
    input  logic [23:0] cfg_data,
    output logic        scl_o,
    output logic        sda_oe,
    input  logic        sda_i
);

    localparam int             TW       = $clog2(CLK_DIV);
    localparam logic [TW-1:0]  TICK_MAX = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0]  TICK_ONE = TW'(1);
    localparam logic [7:0]     LAST_IDX = 8'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_BYTE   = 3'd2,
        S_ACK    = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    state_t          state_r;
    logic [TW-1:0]   tick_cnt_r;
    logic [1:0]      q_r;
    logic [2:0]      bit_cnt_r;
    logic [1:0]      byte_cnt_r;
    logic [23:0]     shadow_r;
    logic            nack_r;
    logic            abort_r;
    logic            retry_r;
    logic            sda_meta_r;
    logic            sda_sync_r;
`ifdef CODEC_CFG_RETRY_EN
    logic [1:0]      retry_cnt_r;
`endif

    logic            tick_s;
    logic            bit_end_s;
    logic            entry_s;
    logic [7:0]      byte_s;
    logic            cur_bit_s;
    logic            scl_s;
    logic            sda_oe_s;

    function automatic logic [7:0] frame_byte(input logic [1:0] sel, input logic [23:0] shadow);
        case (sel)
            2'd0:    frame_byte = {DEV_ADDR, 1'b0};
            2'd1:    frame_byte = shadow[23:16];
            2'd2:    frame_byte = shadow[15:8];
            default: frame_byte = shadow[7:0];
        endcase
    endfunction

    // Quarter-tick decode, current frame bit and bus levels for the present quarter.
    always_comb begin
        tick_s    = (tick_cnt_r == TICK_MAX);
        bit_end_s = tick_s && (q_r == 2'd3);
        entry_s   = (tick_cnt_r == {TW{1'b0}}) && (q_r == 2'd0);
        byte_s    = frame_byte(byte_cnt_r, shadow_r);
        cur_bit_s = byte_s[3'd7 - bit_cnt_r];
        scl_s     = 1'b1;
        sda_oe_s  = 1'b0;
        case (state_r)
            // SDA falls at the Q1/Q2 boundary with SCL held high
            S_START: begin scl_s = 1'b1;             sda_oe_s = q_r[1];     end
            S_BYTE:  begin scl_s = q_r[1];           sda_oe_s = ~cur_bit_s; end
            S_ACK:   begin scl_s = q_r[1];           sda_oe_s = 1'b0;       end
            // SCL rises in Q1, SDA released at the Q1/Q2 boundary
            S_STOP:  begin scl_s = (q_r != 2'd0);    sda_oe_s = ~q_r[1];    end
            default: begin scl_s = 1'b1;             sda_oe_s = 1'b0;       end
        endcase
    end

    // Two-flop synchronizer for the SDA pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
        end else begin
            sda_meta_r <= sda_i;
            sda_sync_r <= sda_meta_r;
        end
    end

    // Sequencer FSM with quarter-tick timing and registered bus/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            tick_cnt_r  <= {TW{1'b0}};
            q_r         <= 2'd0;
            bit_cnt_r   <= 3'd0;
            byte_cnt_r  <= 2'd0;
            shadow_r    <= 24'd0;
            nack_r      <= 1'b0;
            abort_r     <= 1'b0;
            retry_r     <= 1'b0;
`ifdef CODEC_CFG_RETRY_EN
            retry_cnt_r <= 2'd0;
`endif
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            err_idx     <= 8'd0;
            cfg_idx     <= 8'd0;
            scl_o       <= 1'b1;
            sda_oe      <= 1'b0;
        end else begin
            done   <= 1'b0;
            scl_o  <= scl_s;
            sda_oe <= sda_oe_s;

            // Every transition lands on a bit-time boundary, so this also reloads at state entry.
            if ((state_r == S_IDLE) || (state_r == S_FINISH)) begin
                tick_cnt_r <= {TW{1'b0}};
                q_r        <= 2'd0;
            end else if (tick_s) begin
                tick_cnt_r <= {TW{1'b0}};
                q_r        <= q_r + 2'd1;
            end else begin
                tick_cnt_r <= tick_cnt_r + TICK_ONE;
            end

            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        cfg_idx  <= 8'd0;
                        ack_err  <= 1'b0;
                        abort_r  <= 1'b0;
                        retry_r  <= 1'b0;
`ifdef CODEC_CFG_RETRY_EN
                        retry_cnt_r <= 2'd0;
`endif
                        state_r  <= S_START;
                    end
                end
                S_START: begin
                    if (entry_s) begin
                        shadow_r   <= cfg_data;
                        byte_cnt_r <= 2'd0;
                        bit_cnt_r  <= 3'd0;
                    end
                    if (bit_end_s) begin
                        state_r <= S_BYTE;
                    end
                end
                S_BYTE: begin
                    if (bit_end_s) begin
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_r <= 3'd0;
                            state_r   <= S_ACK;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                end
                S_ACK: begin
                    if (tick_s && (q_r == 2'd2)) begin
                        nack_r <= sda_sync_r;
                    end
                    if (bit_end_s) begin
                        if (nack_r) begin
`ifdef CODEC_CFG_RETRY_EN
                            if (retry_cnt_r == 2'd3) begin
                                ack_err <= 1'b1;
                                err_idx <= cfg_idx;
                                abort_r <= 1'b1;
                            end else begin
                                retry_cnt_r <= retry_cnt_r + 2'd1;
                                retry_r     <= 1'b1;
                            end
`else
                            ack_err <= 1'b1;
                            err_idx <= cfg_idx;
                            abort_r <= 1'b1;
`endif
                            state_r <= S_STOP;
                        end else if (byte_cnt_r == 2'd3) begin
                            state_r <= S_STOP;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                            state_r    <= S_BYTE;
                        end
                    end
                end
                S_STOP: begin
                    if (bit_end_s) begin
                        state_r <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (bit_end_s) begin
                        if (abort_r || (!retry_r && (cfg_idx == LAST_IDX))) begin
                            state_r <= S_FINISH;
                        end else if (retry_r) begin
                            retry_r <= 1'b0;
                            state_r <= S_START;
                        end else begin
                            cfg_idx <= cfg_idx + 8'd1;
`ifdef CODEC_CFG_RETRY_EN
                            retry_cnt_r <= 2'd0;
`endif
                            state_r <= S_START;
                        end
                    end
                end
                S_FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    abort_r <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
